lite_cfg_master: RTL

- AXI4-Lite initiator that issues single-beat register reads and writes into the accelerator's AXI-Lite control slave (CTRL/sample/out_ch/kernel/src/dst limit registers).
- Driven by a simple command/response valid-ready port from a local sequencer or testbench.
- Optional poll command re-reads a register until a masked field matches, e.g. waiting for the run bit in CTRL to clear.

---
 rtl/lite_cfg_pkg.sv | 49 ++++
 rtl/lite_poll_ctr.sv | 55 +++++
 rtl/lite_cfg_master.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lite_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lite_cfg_pkg                                                    |
// | Purpose  : Shared definitions for the AXI4-Lite configuration initiator:   |
// |            FSM state encoding, AXI response codes, accelerator register    |
// |            map and a counter-width helper.                                 |
// | Ports    : none (package)                                                  |
// | Options  : LITE_CFG_POLL_EN (consumed by lite_cfg_master)                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package lite_cfg_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR        = 3'd1,
    S_WR_RESP   = 3'd2,
    S_RD_ADDR   = 3'd3,
    S_RD_DATA   = 3'd4,
    S_POLL_WAIT = 3'd5,
    S_RSP       = 3'd6
  } state_t;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Write strobe: every access is a full 32-bit word
  localparam logic [3:0] WSTRB_ALL = 4'hf;

  // Accelerator control-slave register map (byte offsets)
  localparam logic [11:0] REG_CTRL    = 12'h000;
  localparam logic [11:0] REG_SAMPLE  = 12'h004;
  localparam logic [11:0] REG_OUT_CH  = 12'h008;
  localparam logic [11:0] REG_KERNEL  = 12'h00C;
  localparam logic [11:0] REG_SRC_MAX = 12'h010;
  localparam logic [11:0] REG_DST_MAX = 12'h014;

  // CTRL register bit positions
  localparam int CTRL_MATW_BIT = 0;
  localparam int CTRL_RUN_BIT  = 1;
  localparam int CTRL_LAST_BIT = 2;

  // Bits needed to hold the value max_val without wrapping (at least 1)
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lite_poll_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lite_poll_ctr                                                   |
// | Purpose  : Gap and attempt counters for poll commands.                     |
// |            gap_done pulses on the last of POLL_GAP cycles spent with       |
// |            gap_run high; at_max flags that POLL_MAX retries are used up.   |
// | Ports    : clk, rst_n (sync active-low)                                    |
// |            clear       - zero the attempt counter (new command)            |
// |            gap_run     - master is in its inter-poll wait state            |
// |            attempt_inc - one more retry is being started                   |
// |            gap_done    - wait period complete                              |
// |            at_max      - attempt counter equals POLL_MAX                   |
// | Options  : only instantiated when LITE_CFG_POLL_EN is defined              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lite_poll_ctr
  import lite_cfg_pkg::*;
#(
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic gap_run,
  input  logic attempt_inc,
  output logic gap_done,
  output logic at_max
);

  localparam int GAP_W = cnt_width(POLL_GAP);
  localparam int ATT_W = cnt_width(POLL_MAX);

  logic [GAP_W-1:0] r_gap_cnt;
  logic [ATT_W-1:0] r_attempt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gap_cnt <= '0;
      r_attempt <= '0;
    end else begin
      // Gap counter restarts from zero every time the wait state is entered
      if (gap_run) r_gap_cnt <= r_gap_cnt + 1'b1;
      else         r_gap_cnt <= '0;

      if (clear)            r_attempt <= '0;
      else if (attempt_inc) r_attempt <= r_attempt + 1'b1;
    end
  end

  assign gap_done = gap_run && (r_gap_cnt == GAP_W'(POLL_GAP - 1));
  assign at_max   = (r_attempt == ATT_W'(POLL_MAX));

endmodule
`default_nettype wire

// File: rtl/lite_cfg_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lite_cfg_master                                                 |
// | Purpose  : AXI4-Lite initiator issuing single-beat register reads/writes   |
// |            from a valid/ready command port, with an optional poll command  |
// |            that re-reads a register until (RDATA & mask) == (match & mask).|
// | Ports    : M_AXI_ACLK, M_AXI_ARESETN (sync active-low)                     |
// |            cmd_*  - command in  (write / read / poll, addr, data, mask)    |
// |            rsp_*  - response out (data, resp, timeout)                     |
// |            busy   - transaction in progress                                |
// |            M_AXI_* - AXI4-Lite master AW/W/B/AR/R channels                 |
// | Options  : LITE_CFG_POLL_EN - build poll support; when undefined, poll     |
// |            commands run as plain reads and rsp_timeout is tied low.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lite_cfg_master
  import lite_cfg_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 1023
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESETN,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_poll,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  input  logic [31:0]       cmd_mask,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic              busy,
  // AXI4-Lite write address / data / response
  output logic [31:0]       M_AXI_AWADDR,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [31:0]       M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  // AXI4-Lite read address / data
  output logic [31:0]       M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  state_t      r_state;
  logic        r_cmd_ready;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;     // write data, or the match value for a poll
  logic        r_aw_valid;
  logic        r_w_valid;
  logic        r_b_ready;
  logic        r_ar_valid;
  logic        r_r_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic [1:0]  r_rsp_resp;
  logic        r_rsp_timeout;

  // A channel counts as done once its valid has dropped or it handshakes now
  logic w_aw_done;
  logic w_w_done;
  assign w_aw_done = !r_aw_valid || M_AXI_AWREADY;
  assign w_w_done  = !r_w_valid  || M_AXI_WREADY;

`ifdef LITE_CFG_POLL_EN
  logic        r_poll;
  logic [31:0] r_mask;
  logic        w_match;
  logic        w_poll_again;
  logic        w_gap_done;
  logic        w_at_max;
  logic        w_ctr_clear;
  logic        w_gap_run;
  logic        w_attempt_inc;

  assign w_match       = ((M_AXI_RDATA & r_mask) == (r_wdata & r_mask));
  // An error response ends the poll immediately, matching or not
  assign w_poll_again  = r_poll && !w_match && (M_AXI_RRESP == RESP_OKAY);
  assign w_ctr_clear   = (r_state == S_IDLE);
  assign w_gap_run     = (r_state == S_POLL_WAIT);
  assign w_attempt_inc = (r_state == S_RD_DATA) && M_AXI_RVALID && w_poll_again && !w_at_max;

  lite_poll_ctr #(
    .POLL_GAP (POLL_GAP),
    .POLL_MAX (POLL_MAX)
  ) u_poll_ctr (
    .clk         (M_AXI_ACLK),
    .rst_n       (M_AXI_ARESETN),
    .clear       (w_ctr_clear),
    .gap_run     (w_gap_run),
    .attempt_inc (w_attempt_inc),
    .gap_done    (w_gap_done),
    .at_max      (w_at_max)
  );
`else
  // Poll inputs and poll parameters have no function in this build
  logic unused_poll;
  assign unused_poll = ^{cmd_poll, cmd_mask, POLL_GAP[0], POLL_MAX[0]};
`endif

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_aw_valid    <= 1'b0;
      r_w_valid     <= 1'b0;
      r_b_ready     <= 1'b0;
      r_ar_valid    <= 1'b0;
      r_r_ready     <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_resp    <= '0;
      r_rsp_timeout <= 1'b0;
`ifdef LITE_CFG_POLL_EN
      r_poll        <= 1'b0;
      r_mask        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_cmd_ready && cmd_valid) begin
            r_cmd_ready <= 1'b0;
            // Word-aligned, zero-extended address
            r_addr      <= 32'(cmd_addr) & ~32'h3;
            r_wdata     <= cmd_data;
`ifdef LITE_CFG_POLL_EN
            r_poll      <= cmd_poll && !cmd_write;
            r_mask      <= cmd_mask;
`endif
            if (cmd_write) begin
              r_aw_valid <= 1'b1;
              r_w_valid  <= 1'b1;
              r_state    <= S_WR;
            end else begin
              r_ar_valid <= 1'b1;
              r_state    <= S_RD_ADDR;
            end
          end else begin
            // Also raises cmd_ready on the first cycle out of reset
            r_cmd_ready <= 1'b1;
          end
        end

        S_WR: begin
          if (r_aw_valid && M_AXI_AWREADY) r_aw_valid <= 1'b0;
          if (r_w_valid  && M_AXI_WREADY)  r_w_valid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_b_ready <= 1'b1;
            r_state   <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (M_AXI_BVALID) begin
            r_b_ready   <= 1'b0;
            r_rsp_resp  <= M_AXI_BRESP;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end
        end

        S_RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (M_AXI_RVALID) begin
            r_r_ready  <= 1'b0;
            r_rsp_data <= M_AXI_RDATA;
            r_rsp_resp <= M_AXI_RRESP;
`ifdef LITE_CFG_POLL_EN
            if (!w_poll_again) begin
              r_rsp_valid <= 1'b1;
              r_state     <= S_RSP;
            end else if (w_at_max) begin
              r_rsp_timeout <= 1'b1;
              r_rsp_valid   <= 1'b1;
              r_state       <= S_RSP;
            end else begin
              r_state <= S_POLL_WAIT;
            end
`else
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
`endif
          end
        end

`ifdef LITE_CFG_POLL_EN
        S_POLL_WAIT: begin
          if (w_gap_done) begin
            r_ar_valid <= 1'b1;
            r_state    <= S_RD_ADDR;
          end
        end
`endif

        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_cmd_ready   <= 1'b1;
            r_state       <= S_IDLE;
          end
        end

        default: begin
          r_aw_valid  <= 1'b0;
          r_w_valid   <= 1'b0;
          r_b_ready   <= 1'b0;
          r_ar_valid  <= 1'b0;
          r_r_ready   <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign rsp_resp      = r_rsp_resp;
  assign rsp_timeout   = r_rsp_timeout;
  assign busy          = (r_state != S_IDLE);

  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWVALID = r_aw_valid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = WSTRB_ALL;
  assign M_AXI_WVALID  = r_w_valid;
  assign M_AXI_BREADY  = r_b_ready;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARVALID = r_ar_valid;
  assign M_AXI_RREADY  = r_r_ready;

endmodule
`default_nettype wire
